// File: rtl/iob_pulse_gen.sv
// iob_pulse_gen: programmable pulse-train generator.
// After an accepted start it waits `delay` cycles, then emits `npulses` pulses of `width`
// high cycles separated by `gap` low cycles, and strobes done_o once the train completes
// or is aborted by stop_i.
// Optional feature macro: IOB_PULSE_GEN_CONTINUOUS_EN -- when defined, npulses_i == 0 requests
// an unbounded pulse train that ends only on stop_i or reset. When undefined, npulses_i == 0
// completes immediately with a done strobe and no pulse.
//
// The FSM state leads the registered outputs by one cycle: pulse_o/busy_o/done_o reflect the
// state held during the previous enabled cycle. stop_i is the exception: it clears the
// outputs and raises done_o at the same edge that aborts the run.
module iob_pulse_gen #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic [CNT_W-1:0] npulses_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StDelay, StHigh, StGap} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic             evt_q, evt_d;     // completion seen; becomes done_o one cycle later
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] width_eff;
    logic [CNT_W-1:0] gap_eff;
    logic             no_run;

    // Zero width/gap are promoted to one cycle.
    assign width_eff = (width_i == '0) ? CntOne : width_i;
    assign gap_eff   = (gap_i == '0) ? CntOne : gap_i;

`ifdef IOB_PULSE_GEN_CONTINUOUS_EN
    // npulses_i == 0 starts an unbounded train; pulses_q then stays 0 and never hits 1.
    assign no_run = 1'b0;
`else
    assign no_run = (npulses_i == '0);
`endif

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        gap_d    = gap_q;
        pulses_d = pulses_q;
        evt_d    = 1'b0;
        pulse_d  = (state_q == StHigh);
        busy_d   = (state_q != StIdle);
        done_d   = evt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !stop_i) begin
                    width_d  = width_eff;
                    gap_d    = gap_eff;
                    pulses_d = npulses_i;
                    if (no_run) begin
                        evt_d = 1'b1;
                    end else if (delay_i != '0) begin
                        state_d = StDelay;
                        cnt_d   = delay_i;
                    end else begin
                        state_d = StHigh;
                        cnt_d   = width_eff;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == CntOne) begin
                    state_d = StHigh;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHigh: begin
                if (cnt_q == CntOne) begin
                    if (pulses_q == CntOne) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        evt_d   = 1'b1;
                    end else begin
                        state_d = StGap;
                        cnt_d   = gap_q;
                        // A zero count means an unbounded train: leave it at zero.
                        if (pulses_q != '0) begin
                            pulses_d = pulses_q - CntOne;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                if (cnt_q == CntOne) begin
                    state_d = StHigh;
                    cnt_d   = width_q;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase

        // Abort takes effect at this edge, outputs included.
        if (state_q != StIdle && stop_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            evt_d   = 1'b0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    // State and output registers: reset wins over everything, cke_i gates all updates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            pulses_q <= '0;
            evt_q    <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (cke_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            pulses_q <= pulses_d;
            evt_q    <= evt_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_iob_pulse_gen.sv
// tb_iob_pulse_gen: directed and randomized bench for iob_pulse_gen with CNT_W = 4 so that the
// maximum operand value (15) is reachable. A timeline model tracks, for the run in progress,
// how many enabled edges have elapsed since the start edge and derives the expected outputs
// from delay/width/gap arithmetic. Literal expectations pin the model on known sequences.
module tb_iob_pulse_gen;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          cke, rst, start, stop;
    logic [CW-1:0] delay, width, gap, npulses;
    logic          pulse_o, busy_o, done_o;

    int n_total = 0;
    int n_pass  = 0;

    // Model state.
    bit     m_run;
    bit     m_cont;
    longint m_k;
    longint m_t;
    int     m_d, m_w, m_g;
    bit     e_pulse, e_busy, e_done;

    iob_pulse_gen #(
        .CNT_W(CW)
    ) dut (
        .clk_i    (clk),
        .cke_i    (cke),
        .rst_i    (rst),
        .start_i  (start),
        .stop_i   (stop),
        .delay_i  (delay),
        .width_i  (width),
        .gap_i    (gap),
        .npulses_i(npulses),
        .pulse_o  (pulse_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endfunction

    // Pulse level after the k-th enabled edge of the current run (k >= 1).
    function automatic bit pulse_at(longint k);
        longint j;
        j = k - 1 - m_d;
        if (j < 0) return 1'b0;
        return (j % (m_w + m_g)) < m_w;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(bit r, bit c, bit s, bit p, int d, int w, int g, int n);
        bit active;
        if (r) begin
            m_run = 0; e_pulse = 0; e_busy = 0; e_done = 0;
            return;
        end
        if (!c) return;
        active = m_run && (m_cont || m_k < m_t);
        if (active && p) begin
            m_run = 0; e_pulse = 0; e_busy = 0; e_done = 1;
        end else if (active) begin
            m_k++;
            e_busy  = 1;
            e_done  = 0;
            e_pulse = pulse_at(m_k);
        end else begin
            e_pulse = 0;
            e_busy  = 0;
            e_done  = m_run && (m_k == m_t);
            m_run   = 0;
            if (s && !p) begin
                m_d = d;
                m_w = (w == 0) ? 1 : w;
                m_g = (g == 0) ? 1 : g;
`ifdef IOB_PULSE_GEN_CONTINUOUS_EN
                m_cont = (n == 0);
`else
                m_cont = 0;
`endif
                m_t   = (n == 0) ? 0 : longint'(d) + longint'(n) * m_w + longint'(n - 1) * m_g;
                m_k   = 0;
                m_run = 1;
            end
        end
    endtask

    // Drive one cycle (called at a falling edge), then compare at the next falling edge.
    task automatic tick(bit r, bit c, bit s, bit p, int d, int w, int g, int n);
        rst = r; cke = c; start = s; stop = p;
        delay = CW'(d); width = CW'(w); gap = CW'(g); npulses = CW'(n);
        model_step(r, c, s, p, d, w, g, n);
        @(negedge clk);
        check("pulse_o", longint'(pulse_o), longint'(e_pulse));
        check("busy_o", longint'(busy_o), longint'(e_busy));
        check("done_o", longint'(done_o), longint'(e_done));
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) tick(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [11:0] pv, bv, dv;
        int          cnt, first;

        rst = 1; cke = 1; start = 0; stop = 0;
        delay = '0; width = '0; gap = '0; npulses = '0;
        m_run = 0; m_cont = 0; m_k = 0; m_t = 0; m_d = 0; m_w = 1; m_g = 1;
        @(negedge clk);

        // Reset state, with cke low and start/stop high to show reset overrides them.
        tick(1, 0, 1, 1, 3, 3, 3, 3);
        check("reset_outputs", {pulse_o, busy_o, done_o}, 0);
        idle(2);

        // delay=2 width=3 gap=1 npulses=2.
        pv = '0; bv = '0; dv = '0;
        tick(0, 1, 1, 0, 2, 3, 1, 2);
        for (int i = 1; i <= 11; i++) begin
            tick(0, 1, 0, 0, 9, 9, 9, 9);
            pv[i] = pulse_o; bv[i] = busy_o; dv[i] = done_o;
        end
        check("train_pulse", pv[11:1], 11'b00111011100);
        check("train_busy", bv[11:1], 11'b00111111111);
        check("train_done", dv[11:1], 11'b01000000000);
        idle(2);

        // delay=0 width=0 npulses=1.
        pv = '0; dv = '0;
        tick(0, 1, 1, 0, 0, 0, 5, 1);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            pv[i] = pulse_o; dv[i] = done_o;
        end
        check("min_pulse", pv[3:1], 3'b001);
        check("min_done", dv[3:1], 3'b010);
        idle(2);

        // npulses=5, start held during the run is ignored, stop at E4.
        tick(0, 1, 1, 0, 1, 2, 2, 5);
        for (int i = 1; i <= 3; i++) tick(0, 1, 1, 0, 0, 0, 0, 0);
        check("stop_pre_pulse", {pulse_o, busy_o, done_o}, 3'b110);
        tick(0, 1, 0, 1, 0, 0, 0, 0);
        check("stop_abort", {pulse_o, busy_o, done_o}, 3'b001);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        check("stop_after", {pulse_o, busy_o, done_o}, 3'b000);
        idle(2);

        // Reset at E3 mid-HIGH, then start+stop together in IDLE.
        tick(0, 1, 1, 0, 0, 5, 1, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        check("rst_pre_pulse", pulse_o, 1);
        tick(1, 1, 0, 0, 0, 0, 0, 0);
        check("rst_mid_high", {pulse_o, busy_o, done_o}, 3'b000);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            cnt += int'(done_o);
        end
        check("rst_no_done", cnt, 0);
        tick(0, 1, 1, 1, 0, 1, 1, 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            cnt += int'(pulse_o) + int'(busy_o) + int'(done_o);
        end
        check("start_stop_idle", cnt + int'(busy_o), 0);

        // cke low for 4 cycles mid-pulse stretches width 3 to 7 observed cycles.
        cnt = 0;
        tick(0, 1, 1, 0, 0, 3, 1, 1);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        cnt += int'(pulse_o);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0);
            cnt += int'(pulse_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            cnt += int'(pulse_o);
        end
        check("cke_stretch", cnt, 7);

        // Maximum width: exactly 15 high cycles.
        cnt = 0;
        tick(0, 1, 1, 0, 0, 15, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            cnt += int'(pulse_o);
        end
        check("max_width", cnt, 15);

        // Maximum delay: first pulse after E16.
        first = 0;
        tick(0, 1, 1, 0, 15, 1, 1, 1);
        for (int i = 1; i <= 20; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            if (pulse_o && first == 0) first = i;
        end
        check("max_delay", first, 16);

        // npulses=0.
        tick(0, 1, 1, 0, 0, 1, 1, 0);
`ifdef IOB_PULSE_GEN_CONTINUOUS_EN
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 1, 0, 0, 0, 0, 0, 0);
            cnt += int'(pulse_o);
        end
        check("cont_pulses", cnt, 15);
        check("cont_busy", busy_o, 1);
        tick(0, 1, 0, 1, 0, 0, 0, 0);
        check("cont_stop", {pulse_o, busy_o, done_o}, 3'b001);
`else
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        check("zero_done", {pulse_o, busy_o, done_o}, 3'b001);
        tick(0, 1, 0, 0, 0, 0, 0, 0);
        check("zero_after", {pulse_o, busy_o, done_o}, 3'b000);
`endif
        idle(2);

        // Randomized stimulus; operands change freely while a run is in progress.
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 7) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/iob_pulse_gen.md
IOB_PULSE_GEN -- requirements
Module: iob_pulse_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, giving the width of the delay, width, gap and count operands.
REQ-002 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port cke_i, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-004 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port start_i, input, 1 bit: start request, sampled only in IDLE.
REQ-006 The module SHALL have port stop_i, input, 1 bit: abort request.
REQ-007 The module SHALL have port delay_i, input, CNT_W bits: cycles from start acceptance to the first pulse.
REQ-008 The module SHALL have port width_i, input, CNT_W bits: high time per pulse, in cycles.
REQ-009 The module SHALL have port gap_i, input, CNT_W bits: low time between pulses, in cycles.
REQ-010 The module SHALL have port npulses_i, input, CNT_W bits: number of pulses to emit.
REQ-011 The module SHALL have port pulse_o, output, 1 bit: generated pulse train, registered.
REQ-012 The module SHALL have port busy_o, output, 1 bit: high in any state other than IDLE, registered.
REQ-013 The module SHALL have port done_o, output, 1 bit: one-cycle completion strobe, registered.

Function
REQ-014 The FSM SHALL have states IDLE, DELAY, HIGH and GAP; all edges referenced below are clock edges with cke_i=1.
REQ-015 Start is accepted at edge E0 when the FSM is in IDLE with start_i=1 and stop_i=0; delay_i, width_i, gap_i and npulses_i SHALL be captured at E0, and later operand changes SHALL have no effect on the run in progress.
REQ-016 Given captured delay D, pulse_o SHALL rise at edge E(D+1): with D>0 the FSM passes through DELAY for D cycles, and with D=0 it enters HIGH directly at E1.
REQ-017 pulse_o SHALL stay high for W cycles; a width_i of 0 SHALL be treated as W=1.
REQ-018 Between consecutive pulses, pulse_o SHALL stay low for G cycles (state GAP); a gap_i of 0 SHALL be treated as G=1.
REQ-019 After the last high cycle the FSM SHALL return to IDLE with no trailing gap, and done_o SHALL be high for exactly the first cycle of IDLE, coincident with pulse_o=0 and busy_o=0.
REQ-020 start_i SHALL be ignored while busy_o=1; a start_i held high continuously across completion SHALL restart the generator at the first IDLE edge.
REQ-021 stop_i=1 while busy SHALL move the FSM to IDLE at that edge, with pulse_o=0 and done_o=1 for one cycle.
REQ-022 start_i=1 together with stop_i=1 in IDLE SHALL do nothing: no run starts and done_o stays 0.
REQ-023 Internal counters SHALL be CNT_W bits and down-counting, and SHALL never wrap; the maximum operand value (2^CNT_W-1) SHALL be honored exactly.
REQ-024 When cke_i=0 the FSM, counters and all outputs SHALL hold, including a pending done_o.

Reset
REQ-025 rst_i=1 at an edge SHALL force IDLE, clear all counters, and drive pulse_o=0, busy_o=0 and done_o=0, overriding cke_i, start_i and stop_i.
REQ-026 Reset mid-run SHALL abort the run without asserting done_o.

Configuration
REQ-027 Macro IOB_PULSE_GEN_CONTINUOUS_EN defined: npulses_i=0 SHALL mean an unbounded pulse train that ends only on stop_i or reset.
REQ-028 Macro IOB_PULSE_GEN_CONTINUOUS_EN undefined: npulses_i=0 SHALL emit no pulse, with the FSM going IDLE->IDLE, busy_o staying 0, and done_o=1 at E1.

Verification
REQ-029 Bench SHALL check: delay=2, width=3, gap=1, npulses=2, start at E0 -> pulse_o high after E3..E5, low after E6, high after E7..E9; done_o only after E10; busy_o high after E1..E9.
REQ-030 Bench SHALL check: delay=0, width=0, npulses=1 -> pulse_o high only after E1, done_o after E2.
REQ-031 Bench SHALL check: npulses=5, stop_i at E4 -> pulse_o=0, busy_o=0 and done_o=1 after E4; start_i asserted during the run is ignored.
REQ-032 Bench SHALL check: rst_i at E3 mid-HIGH -> all outputs 0 after E3 and no done_o; start_i+stop_i in IDLE -> no activity.
REQ-033 Bench SHALL check: cke_i low for 4 cycles mid-pulse -> pulse_o high time extended by exactly 4 cycles; CNT_W=4 with width=15 -> exactly 15 high cycles.
REQ-034 Bench SHALL check: npulses=0 -> with IOB_PULSE_GEN_CONTINUOUS_EN, pulses repeat until stop_i; without it, done_o after E1 and no pulse.
